// File: rtl/mux_nx1_reg_if.sv
// Handshake bundle for mux_nx1_reg: N-channel source bus, select/mode and valid/ready on both sides.
// out_par exists only when MUX_NX1_PARITY_EN is defined.
interface mux_nx1_reg_if #(
  parameter int N = 64,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;
  logic           sel_err;
`ifdef MUX_NX1_PARITY_EN
  logic           out_par;

  modport master (
    output din, sel, mode, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, sel_err, out_par
  );
  modport slave (
    input  din, sel, mode, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, sel_err, out_par
  );
`else
  modport master (
    output din, sel, mode, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, sel_err
  );
  modport slave (
    input  din, sel, mode, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, sel_err
  );
`endif
endinterface

// File: rtl/mux_nx1_reg.sv
// N-input, W-bit registered multiplexer with valid/ready on both sides, direct or round-robin scan select.
// Optional macro MUX_NX1_PARITY_EN adds a registered even-parity output (out_par).
module mux_nx1_reg #(
  parameter int N = 64,
  parameter int W = 8
) (
  input logic          clk,
  input logic          rst_n,
  mux_nx1_reg_if.slave bus
);
  localparam int SW = $clog2(N);

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  mode_e         mode_q;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_base;
  logic [SW-1:0] ptr_next;
  logic [SW-1:0] ch;
  logic [W-1:0]  ch_data;
  logic          scan_entry;
  logic          in_range;
  logic          err_d;
  logic          accept;

  logic [W-1:0]  data_q;
  logic [SW-1:0] ch_q;
  logic          valid_q;
  logic          err_q;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Scan entry forces the pointer to channel 0 in the same cycle, so the entry beat uses channel 0.
  always_comb begin
    scan_entry = bus.mode && (mode_q == MODE_DIRECT);
    ptr_base   = scan_entry ? '0 : ptr;
    ch         = bus.mode ? ptr_base : bus.sel;
    in_range   = 32'(ch) < 32'(N);
    err_d      = !bus.mode && !in_range;
    ptr_next   = ptr_base;
    if (bus.mode && accept) begin
      ptr_next = (ptr_base == SW'(N - 1)) ? '0 : ptr_base + 1'b1;
    end
  end

  // Out-of-range selects match no channel and therefore yield zero data.
  always_comb begin
    ch_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ch == SW'(i)) ch_data = bus.din[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_DIRECT;
      ptr    <= '0;
    end else begin
      mode_q <= mode_e'(bus.mode);
      ptr    <= ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      data_q  <= ch_data;
      ch_q    <= ch;
      valid_q <= 1'b1;
      err_q   <= err_d;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;
  assign bus.sel_err   = err_q;

`ifdef MUX_NX1_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par_q <= 1'b0;
    else if (accept) par_q <= ^ch_data;
  end

  assign bus.out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Bench for mux_nx1_reg: two instances (N=64 and N=48, W=8) share one stimulus stream and are
// checked every cycle against a transaction-level model plus hand-computed literals.
module tb_mux_nx1_reg;
  logic clk = 1'b0;
  logic rst_n;
  logic mode;
  logic in_valid;
  logic out_ready;
  logic [5:0] sel;
  logic [7:0] src [64];
  logic [64*8-1:0] din64;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    din64 = '0;
    for (int i = 0; i < 64; i++) din64[i*8 +: 8] = src[i];
  end

  mux_nx1_reg_if #(.N(64), .W(8)) bus64 ();
  mux_nx1_reg_if #(.N(48), .W(8)) bus48 ();

  assign bus64.din       = din64;
  assign bus64.sel       = sel;
  assign bus64.mode      = mode;
  assign bus64.in_valid  = in_valid;
  assign bus64.out_ready = out_ready;
  assign bus48.din       = din64[48*8-1:0];
  assign bus48.sel       = sel;
  assign bus48.mode      = mode;
  assign bus48.in_valid  = in_valid;
  assign bus48.out_ready = out_ready;

  mux_nx1_reg #(.N(64), .W(8)) u64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
  mux_nx1_reg #(.N(48), .W(8)) u48 (.clk(clk), .rst_n(rst_n), .bus(bus48));

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [5:0] ch;
    logic       err;
    logic       par;
    int         ptr;
    logic       mode_prev;
  } mstate_t;

  mstate_t m [2];

  function automatic mstate_t mreset();
    mstate_t r;
    r.valid = 1'b0; r.data = '0; r.ch = '0; r.err = 1'b0; r.par = 1'b0;
    r.ptr = 0; r.mode_prev = 1'b0;
    return r;
  endfunction

  // One clock of the output stage for an n-channel mux, from the beat-level rules.
  function automatic mstate_t mstep(mstate_t s, int n);
    mstate_t r = s;
    int ch;
    logic acc;
    acc = in_valid && (!s.valid || out_ready);
    if (mode) begin
      ch = s.mode_prev ? s.ptr : 0;
      r.ptr = ch;
    end else begin
      ch = int'(sel);
    end
    if (acc) begin
      r.valid = 1'b1;
      r.ch    = 6'(ch);
      if (!mode && ch >= n) begin
        r.data = '0; r.err = 1'b1; r.par = 1'b0;
      end else begin
        r.data = src[ch]; r.err = 1'b0; r.par = ^src[ch];
      end
      if (mode) r.ptr = (ch + 1) % n;
    end else if (out_ready) begin
      r.valid = 1'b0;
    end
    r.mode_prev = mode;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= mreset();
      m[1] <= mreset();
    end else begin
      m[0] <= mstep(m[0], 64);
      m[1] <= mstep(m[1], 48);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready64",  32'(bus64.in_ready),  32'(!m[0].valid || out_ready));
    chk("out_valid64", 32'(bus64.out_valid), 32'(m[0].valid));
    chk("out_data64",  32'(bus64.out_data),  32'(m[0].data));
    chk("out_ch64",    32'(bus64.out_ch),    32'(m[0].ch));
    chk("sel_err64",   32'(bus64.sel_err),   32'(m[0].err));
    chk("in_ready48",  32'(bus48.in_ready),  32'(!m[1].valid || out_ready));
    chk("out_valid48", 32'(bus48.out_valid), 32'(m[1].valid));
    chk("out_data48",  32'(bus48.out_data),  32'(m[1].data));
    chk("out_ch48",    32'(bus48.out_ch),    32'(m[1].ch));
    chk("sel_err48",   32'(bus48.sel_err),   32'(m[1].err));
`ifdef MUX_NX1_PARITY_EN
    chk("out_par64",   32'(bus64.out_par),   32'(m[0].par));
    chk("out_par48",   32'(bus48.out_par),   32'(m[1].par));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 64; i++) src[i] = 8'(8'h10 + i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready64",  32'(bus64.in_ready),  32'd1);
    chk("rst_out_valid64", 32'(bus64.out_valid), 32'd0);
    chk("rst_out_data64",  32'(bus64.out_data),  32'd0);
    chk("rst_out_ch48",    32'(bus48.out_ch),    32'd0);
    chk("rst_sel_err48",   32'(bus48.sel_err),   32'd0);
    rst_n = 1'b1;
    step();

    // Direct select
    sel = 6'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_valid64", 32'(bus64.out_valid), 32'd1);
    chk("t1_data64",  32'(bus64.out_data),  32'h15);
    chk("t1_ch64",    32'(bus64.out_ch),    32'd5);
    chk("t1_err64",   32'(bus64.sel_err),   32'd0);
    chk("t1_model",   32'(m[0].data),       32'h15);
    step();
    chk("t1_drain_valid64", 32'(bus64.out_valid), 32'd0);
    chk("t1_drain_hold64",  32'(bus64.out_data),  32'h15);

    // Backpressure: held beat survives din and mode changes
    out_ready = 1'b0; sel = 6'd3; in_valid = 1'b1;
    step();
    chk("t2_first64", 32'(bus64.out_data), 32'h13);
    sel = 6'd7; src[3] = 8'hAA; mode = 1'b1;
    step();
    mode = 1'b0;
    chk("t2_hold64",     32'(bus64.out_data),  32'h13);
    chk("t2_in_ready64", 32'(bus64.in_ready),  32'd0);
    chk("t2_valid64",    32'(bus64.out_valid), 32'd1);
    step();
    chk("t2_hold2_64", 32'(bus64.out_data), 32'h13);
    src[3] = 8'h13; out_ready = 1'b1;
    #1;
    chk("t2_ready_comb64", 32'(bus64.in_ready), 32'd1);
    step();
    chk("t2_next64", 32'(bus64.out_data), 32'h17);
    chk("t2_ch64",   32'(bus64.out_ch),   32'd7);
    in_valid = 1'b0;
    step();

    // Out-of-range select on the 48-channel instance
    sel = 6'd50; in_valid = 1'b1;
    step();
    chk("t4_data48", 32'(bus48.out_data), 32'd0);
    chk("t4_ch48",   32'(bus48.out_ch),   32'd50);
    chk("t4_err48",  32'(bus48.sel_err),  32'd1);
    chk("t4_data64", 32'(bus64.out_data), 32'h42);
    chk("t4_model",  32'(m[1].err),       32'd1);
    sel = 6'd47;
    step();
    chk("t4b_err48",  32'(bus48.sel_err),  32'd0);
    chk("t4b_data48", 32'(bus48.out_data), 32'h3F);
    in_valid = 1'b0;
    step();

    // Scan from idle with wrap
    mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 66; k++) begin
      step();
      if (k == 0)  chk("t3_first64", 32'(bus64.out_ch), 32'd0);
      if (k == 47) chk("t3_last48",  32'(bus48.out_ch), 32'd47);
      if (k == 48) chk("t3_wrap48",  32'(bus48.out_ch), 32'd0);
      if (k == 63) chk("t3_last64",  32'(bus64.out_data), 32'h4F);
      if (k == 64) chk("t3_wrap64",  32'(bus64.out_ch), 32'd0);
      if (k == 65) begin
        chk("t3_after64",   32'(bus64.out_ch),   32'd1);
        chk("t3_after48",   32'(bus48.out_ch),   32'd17);
        chk("t3_data48",    32'(bus48.out_data), 32'h21);
        chk("t3_model_ptr", 32'(m[0].ptr),       32'd2);
      end
    end

    // Reset while scanning at pointer 20
    for (int k = 0; k < 18; k++) step();
    chk("t5_pre_ch64", 32'(bus64.out_ch), 32'd19);
    chk("t5_pre_ch48", 32'(bus48.out_ch), 32'd35);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid64", 32'(bus64.out_valid), 32'd0);
    chk("t5_async_valid48", 32'(bus48.out_valid), 32'd0);
    chk("t5_async_data64",  32'(bus64.out_data),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_first64", 32'(bus64.out_ch),   32'd0);
    chk("t5_data64",  32'(bus64.out_data), 32'h10);
    chk("t5_first48", 32'(bus48.out_ch),   32'd0);
    step();
    chk("t5_second64", 32'(bus64.out_ch), 32'd1);

    // Parity beats
    mode = 1'b0; src[9] = 8'b1011_0000; sel = 6'd9;
    step();
    chk("t6_data64", 32'(bus64.out_data), 32'hB0);
`ifdef MUX_NX1_PARITY_EN
    chk("t6_par9", 32'(bus64.out_par), 32'd1);
`endif
    src[2] = 8'hF0; sel = 6'd2;
    step();
    chk("t6_data2", 32'(bus64.out_data), 32'hF0);
`ifdef MUX_NX1_PARITY_EN
    chk("t6_par2", 32'(bus64.out_par), 32'd0);
`endif
    in_valid = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux_nx1_reg.md
Name: mux_nx1_reg

Overview:
Parametrised N-input, W-bit registered multiplexer with a valid/ready handshake on both sides.
- Two channel-selection modes: direct (external select) and scan (internal round-robin pointer).
- Used wherever one of many equal-width sources is forwarded onto a single pipelined datapath.
- Flags select values outside the valid channel range.

Parameters:
N, 64, number of input channels (2..256; need not be a power of two)
W, 8, data width per channel in bits
(derived localparam SW = $clog2(N), select width)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
din  in  N*W  flattened inputs; channel i occupies din[i*W +: W]
sel  in  SW  channel select, used in direct mode
mode  in  1  0 = direct, 1 = scan
in_valid  in  1  request to forward one beat
in_ready  out  1  block can accept a beat this cycle
out_data  out  W  registered selected data
out_ch  out  SW  channel index that produced out_data
out_valid  out  1  out_data/out_ch/sel_err valid
out_ready  in  1  downstream accepts the beat
sel_err  out  1  beat came from an out-of-range select (direct mode only)

Behaviour:
- Single clock domain: clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_data=0, out_ch=0, out_valid=0, sel_err=0, scan pointer=0, mode_q=0.
- in_ready is combinational: in_ready = !out_valid || out_ready. It is 1 immediately after reset.
- Accept occurs when in_valid && in_ready. On accept, the following load on the next clk edge:
  - out_data = din slice of the chosen channel
  - out_ch = chosen channel
  - sel_err per the range check below
  - out_valid = 1
- Latency is 1 cycle from accept to out_valid.
- If there is no accept and out_ready=1, out_valid clears to 0. The data registers hold.
- While out_valid=1 and out_ready=0, all output registers hold stable. No beat is dropped or overwritten.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1) gives full throughput of 1 beat per cycle.
- Direct mode: chosen channel = sel.
  - If sel >= N: out_data=0, out_ch=sel, sel_err=1.
  - Otherwise sel_err=0.
- Scan mode: chosen channel = scan pointer. sel is ignored and sel_err is always 0.
  - The pointer increments only on accept.
  - The pointer wraps from N-1 to 0.
- mode_q is mode registered each cycle. When mode=1 and mode_q=0 (scan entry), the pointer is forced to 0 that cycle. The beat accepted in that cycle uses channel 0.
- A mode change while a beat is stalled at the output does not alter the held beat.
- din is sampled only on the accepting edge. Changes on din at other times have no effect.
- rst_n asserted mid-operation: outputs go to reset values immediately (asynchronously). Any in-flight beat is discarded.

Optional Feature:
Macro MUX_NX1_PARITY_EN.
- Defined: adds output port out_par (1 bit), the even parity (XOR reduction) of the selected data.
  - Registered with out_data and held with it under backpressure.
  - Reset value 0.
  - For sel_err beats, out_par = 0.
- Undefined: port out_par and its register are absent. All other behaviour is identical.

Test Plan:
1. Direct select: N=64, W=8, din[i]=8'h10+i, mode=0, sel=5, in_valid=1 for one cycle -> next cycle out_valid=1, out_data=8'h15, out_ch=5, sel_err=0.
2. Backpressure: out_ready=0; beat sel=3, then sel=7 presented -> out_data=8'h13 holds and in_ready=0. Raise out_ready -> sel=7 beat accepted, out_data=8'h17 the following cycle, no loss.
3. Scan wrap: mode=1 from idle, in_valid=1, out_ready=1 for 66 cycles -> out_ch sequence 0,1,...,63,0,1. out_data=8'h10+out_ch, one beat per cycle.
4. Out-of-range: N=48, mode=0, sel=50 -> out_data=0, out_ch=50, sel_err=1. Next beat sel=47 -> sel_err=0.
5. Reset mid-stream: scan running at pointer 20 with out_valid=1, pulse rst_n low -> out_valid=0 immediately. After release, the first scan beat has out_ch=0.
6. Parity (MUX_NX1_PARITY_EN defined): din[9]=8'b1011_0000, sel=9 -> out_par=1. din[2]=8'hF0, sel=2 -> out_par=0.
